psf_dmem_ram_p: RTL and testbench

//  Parametrised single-port data RAM with per-byte write strobes and a valid/ready request port.

---
 rtl/psf_dmem_ram_p_pkg.sv | 14 +
 rtl/psf_dmem_ram_p_if.sv | 28 ++
 rtl/psf_dmem_ram_p_core.sv | 31 +++
 rtl/psf_dmem_ram_p.sv | 163 ++++++++++++++++
 tb/tb_psf_dmem_ram_p.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/psf_dmem_ram_p_pkg.sv
// Shared definitions for the psf data-memory family: read-during-write mode
// encodings and the wrapper FSM state type.
package psf_mem_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } psf_mem_state_e;

endpackage

// File: rtl/psf_dmem_ram_p_if.sv
// Request/response bus of the data RAM; the requester holds the master
// modport, the memory the slave modport.
interface psf_dmem_ram_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rd;
  logic [BYTES-1:0]  req_wstrb;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              init_done;

  modport master (
    output req_valid, req_addr, req_rd, req_wstrb, req_wdata,
    input  req_ready, rsp_valid, rsp_data, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_rd, req_wstrb, req_wdata,
    output req_ready, rsp_valid, rsp_data, init_done
  );
endinterface

// File: rtl/psf_dmem_ram_p_core.sv
// Bare read-first RAM array with per-byte write enables. Registered read and
// no reset so that it maps onto block RAM.
module psf_ram_bytewe_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk_i,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Read the old word and write enabled bytes on the same edge.
  always_ff @(posedge clk_i) begin
    rdata_r <= mem_r[addr];
    for (int b = 0; b < BYTES; b++) begin
      if (we[b]) begin
        mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/psf_dmem_ram_p.sv
// Parametrised single-port data RAM: byte strobes, valid/ready requests,
// fixed-latency responses, selectable read-during-write and post-reset clear.
module psf_dmem_ram_p
  import psf_mem_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 8,
  parameter int                READ_MODE    = 0,
  parameter int                OUT_REG      = 0,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = {DATA_W{1'b0}}
) (
  input logic                clk_i,
  input logic                rst_n_i,
  psf_dmem_ram_p_if.slave    bus
);
  localparam int                BYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  psf_mem_state_e    state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              ready_r;
  logic              done_r;

  logic              sweep_s;
  logic              accept_s;
  logic [ADDR_W-1:0] core_addr_s;
  logic [BYTES-1:0]  core_we_s;
  logic [DATA_W-1:0] core_wdata_s;
  logic [DATA_W-1:0] core_rdata_s;
  logic [DATA_W-1:0] wmask_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              rsp_valid_s;
  logic [DATA_W-1:0] rsp_data_s;

  logic              v1_r;
  logic [DATA_W-1:0] mask_r;
  logic [DATA_W-1:0] wdata_r;
  logic              v2_r;
  logic [DATA_W-1:0] d2_r;

  // Bring-up FSM: optional clear sweep, then open the request port.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_RESET;
      clr_cnt_r <= {ADDR_W{1'b0}};
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          clr_cnt_r <= {ADDR_W{1'b0}};
          if (CLEAR_ON_RST != 0) begin
            state_r <= ST_CLEAR;
          end else begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_r == CNT_LAST) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          ready_r <= 1'b1;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_RESET;
          ready_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates both write sources so that reset alone never alters the array.
  always_comb begin
    sweep_s  = (state_r == ST_CLEAR) & rst_n_i;
    accept_s = bus.req_valid & ready_r & rst_n_i;
    if (sweep_s) begin
      core_addr_s  = clr_cnt_r;
      core_we_s    = {BYTES{1'b1}};
      core_wdata_s = CLEAR_VAL;
    end else begin
      core_addr_s  = bus.req_addr;
      core_we_s    = accept_s ? bus.req_wstrb : {BYTES{1'b0}};
      core_wdata_s = bus.req_wdata;
    end
  end

  // Expand byte strobes into a bit mask.
  always_comb begin
    wmask_s = {DATA_W{1'b0}};
    for (int b = 0; b < BYTES; b++) begin
      wmask_s[8*b +: 8] = {8{bus.req_wstrb[b]}};
    end
  end

  psf_ram_bytewe_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i (clk_i),
    .addr  (core_addr_s),
    .we    (core_we_s),
    .wdata (core_wdata_s),
    .rdata (core_rdata_s)
  );

  // First response stage, aligned with the core's registered read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v1_r    <= 1'b0;
      mask_r  <= {DATA_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      v1_r <= accept_s & bus.req_rd;
      if (accept_s) begin
        mask_r  <= wmask_s;
        wdata_r <= bus.req_wdata;
      end
    end
  end

  assign rd_word_s = (READ_MODE == WR_FIRST) ?
                     ((core_rdata_s & ~mask_r) | (wdata_r & mask_r)) : core_rdata_s;

  // Optional output stage; unused logic is trimmed when OUT_REG is 0.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v2_r <= 1'b0;
      d2_r <= {DATA_W{1'b0}};
    end else begin
      v2_r <= v1_r;
      d2_r <= v1_r ? rd_word_s : {DATA_W{1'b0}};
    end
  end

  // Select the response stage and hold data at zero between pulses.
  always_comb begin
    if (OUT_REG != 0) begin
      rsp_valid_s = v2_r;
      rsp_data_s  = d2_r;
    end else begin
      rsp_valid_s = v1_r;
      rsp_data_s  = v1_r ? rd_word_s : {DATA_W{1'b0}};
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.init_done = done_r;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = rsp_data_s;

endmodule

// File: tb/tb_psf_dmem_ram_p.sv
// Bench for psf_dmem_ram_p: two configurations (read-first/1-cycle/cleared and
// write-first/2-cycle/uncleared) against a word-array reference model.
module tb_psf_dmem_ram_p;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  a;
    logic        rd;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic [31:0] xa;
    logic [31:0] xb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic supp_b = 1'b0;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  exp_t qa[$];
  exp_t qb[$];
  vec_t tab[$];
  exp_t ea_e, eb_e;
  logic ev_a, ev_b;
  int   na, nb;

  psf_dmem_ram_p_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
  psf_dmem_ram_p_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  psf_dmem_ram_p #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0),
                   .CLEAR_ON_RST(1), .CLEAR_VAL(32'h0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .bus(ifa));

  psf_dmem_ram_p #(.DATA_W(32), .ADDR_W(4), .READ_MODE(1), .OUT_REG(1),
                   .CLEAR_ON_RST(0), .CLEAR_VAL(32'h0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .bus(ifb));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor: each pulse must land on its scheduled cycle with its data.
  always @(negedge clk) begin
    ev_a = (qa.size() != 0) && (qa[0].cyc == cyc);
    chk("a_rsp_valid", {31'b0, ifa.rsp_valid}, {31'b0, ev_a});
    if (ev_a) begin
      ea_e = qa.pop_front();
      if (ifa.rsp_valid) chk("a_rsp_data", ifa.rsp_data, ea_e.data);
    end else chk("a_idle_data", ifa.rsp_data, 32'h0);
    ev_b = (qb.size() != 0) && (qb[0].cyc == cyc);
    chk("b_rsp_valid", {31'b0, ifb.rsp_valid}, {31'b0, ev_b});
    if (ev_b) begin
      eb_e = qb.pop_front();
      if (ifb.rsp_valid) chk("b_rsp_data", ifb.rsp_data, eb_e.data);
    end else chk("b_idle_data", ifb.rsp_data, 32'h0);
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] ws,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One request per call; tab=1 takes expected data from the caller instead of the model.
  task automatic drive(input logic [3:0] a, input logic rd, input logic [3:0] ws,
                       input logic [31:0] wd, input logic en_a, input logic en_b,
                       input logic tab_mode, input logic [31:0] xa, input logic [31:0] xb);
    logic [31:0] old;
    @(negedge clk);
    ifa.req_valid = en_a; ifb.req_valid = en_b;
    ifa.req_addr = a;     ifb.req_addr = a;
    ifa.req_rd = rd;      ifb.req_rd = rd;
    ifa.req_wstrb = ws;   ifb.req_wstrb = ws;
    ifa.req_wdata = wd;   ifb.req_wdata = wd;
    if (en_a && ifa.req_ready) begin
      old = mem_a[a];
      if (rd) qa.push_back('{data: (tab_mode ? xa : old), cyc: cyc + 1});
      mem_a[a] = merge(old, ws, wd);
    end
    if (en_b && ifb.req_ready) begin
      old = merge(mem_b[a], ws, wd);
      if (rd && !supp_b) qb.push_back('{data: (tab_mode ? xb : old), cyc: cyc + 2});
      mem_b[a] = old;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
  endtask

  task automatic add(input logic [3:0] a, input logic rd, input logic [3:0] ws,
                     input logic [31:0] wd, input logic [31:0] xa, input logic [31:0] xb);
    tab.push_back('{a: a, rd: rd, ws: ws, wd: wd, xa: xa, xb: xb});
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_addr = 4'h0; ifa.req_rd = 1'b0;
    ifa.req_wstrb = 4'h0; ifa.req_wdata = 32'h0;
    ifb.req_valid = 1'b0; ifb.req_addr = 4'h0; ifb.req_rd = 1'b0;
    ifb.req_wstrb = 4'h0; ifb.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("a_rst_ready", {31'b0, ifa.req_ready}, 32'h0);
    chk("a_rst_done",  {31'b0, ifa.init_done}, 32'h0);
    chk("b_rst_ready", {31'b0, ifb.req_ready}, 32'h0);
    chk("b_rst_done",  {31'b0, ifb.init_done}, 32'h0);

    // Bring-up latency: sweep of 16 words plus one cycle, versus one cycle.
    rst_a = 1'b1; rst_b = 1'b1;
    na = 0; nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (na == 0 && ifa.req_ready) na = i;
      if (nb == 0 && ifb.req_ready) nb = i;
    end
    chk("a_ready_latency", 32'(na), 32'd17);
    chk("b_ready_latency", 32'(nb), 32'd1);
    chk("a_init_done", {31'b0, ifa.init_done}, 32'h1);
    chk("b_init_done", {31'b0, ifb.init_done}, 32'h1);

    // Cleared array reads back zero everywhere.
    for (int k = 0; k < 16; k++) mem_a[k] = 32'h0;
    for (int k = 0; k < 16; k++) drive(4'(k), 1'b1, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 16; k++) drive(4'(k), 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);

    // Directed vectors: byte merge, read-during-write, bursts with interleaved writes.
    add(4'd3, 1'b0, 4'hF, 32'hAABBCCDD, 32'h0, 32'h0);
    add(4'd3, 1'b0, 4'h5, 32'h11223344, 32'h0, 32'h0);
    add(4'd3, 1'b1, 4'h0, 32'h0, 32'hAA22CC44, 32'hAA22CC44);
    add(4'd5, 1'b0, 4'hF, 32'h12345678, 32'h0, 32'h0);
    add(4'd5, 1'b1, 4'h3, 32'hFFFFFFFF, 32'h12345678, 32'h1234FFFF);
    add(4'd5, 1'b1, 4'h0, 32'h0, 32'h1234FFFF, 32'h1234FFFF);
    for (int k = 0; k < 8; k++) add(4'(k), 1'b0, 4'hF, 32'h100 + 32'(k), 32'h0, 32'h0);
    for (int k = 0; k < 8; k++) add(4'(k), 1'b1, 4'h0, 32'h0, 32'h100 + 32'(k), 32'h100 + 32'(k));
    add(4'd0, 1'b1, 4'h0, 32'h0, 32'h100, 32'h100);
    add(4'd9, 1'b0, 4'hF, 32'hDEAD0009, 32'h0, 32'h0);
    add(4'd1, 1'b1, 4'h0, 32'h0, 32'h101, 32'h101);
    add(4'd10, 1'b0, 4'h0, 32'hFFFFFFFF, 32'h0, 32'h0);
    add(4'd10, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    add(4'd9, 1'b1, 4'h0, 32'h0, 32'hDEAD0009, 32'hDEAD0009);
    foreach (tab[i])
      drive(tab[i].a, tab[i].rd, tab[i].ws, tab[i].wd, 1'b1, 1'b1, 1'b1, tab[i].xa, tab[i].xb);

    // Random traffic against the word-array model.
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom),
            $urandom, v, v, 1'b0, 32'h0, 32'h0);
    end
    repeat (3) idle();

    // Reset with a read in flight on the 2-cycle instance; contents must survive.
    drive(4'd3, 1'b0, 4'hF, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(4'd3, 1'b0, 4'h5, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    supp_b = 1'b1;
    drive(4'd3, 1'b1, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    ifb.req_valid = 1'b0; rst_b = 1'b0; supp_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_inflight_valid", {31'b0, ifb.rsp_valid}, 32'h0);
      chk("b_inflight_data", ifb.rsp_data, 32'h0);
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_rerelease_ready", {31'b0, ifb.req_ready}, 32'h1);
    drive(4'd3, 1'b1, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hAA22CC44);
    repeat (3) idle();

    // Reset during the sweep at count 7; sweep restarts from 0.
    @(negedge clk); rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk); rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    na = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (na == 0 && ifa.req_ready) na = i;
    end
    chk("a_abort_ready_latency", 32'(na), 32'd17);
    for (int k = 0; k < 16; k++) mem_a[k] = 32'h0;
    for (int k = 0; k < 16; k++) drive(4'(k), 1'b1, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) idle();

    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
